// File: rtl/mt_pkg.sv
// Shared constants and types for the barrel-threaded mt_cpu core.
// The thread tag type is reused by pipeline tag registers and the register file.
package mt_pkg;

    localparam int unsigned NUM_THREADS      = 4;
    localparam int unsigned TID_WIDTH        = $clog2(NUM_THREADS);
    localparam int unsigned ADDRESS_WIDTH    = 32;
    localparam logic [31:0] RESET_PC         = 32'h0000_0000;
    localparam logic [31:0] THREAD_PC_STRIDE = 32'h0000_0100;
    localparam int unsigned PC_INC           = 4;

    typedef logic [TID_WIDTH-1:0] tid_t;

endpackage

// File: rtl/thread_pc_file.sv
// Per-thread PC array: one read port, one increment write and one redirect write.
// A redirect to the same thread overrides the increment.
module thread_pc_file #(
    parameter int unsigned                 NUM_THREADS      = mt_pkg::NUM_THREADS,
    parameter int unsigned                 ADDRESS_WIDTH    = mt_pkg::ADDRESS_WIDTH,
    parameter logic [ADDRESS_WIDTH-1:0]    RESET_PC         = mt_pkg::RESET_PC,
    parameter logic [ADDRESS_WIDTH-1:0]    THREAD_PC_STRIDE = mt_pkg::THREAD_PC_STRIDE
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [$clog2(NUM_THREADS)-1:0] rd_tid,
    output logic [ADDRESS_WIDTH-1:0]       rd_pc,
    input  logic                           inc_en,
    input  logic [$clog2(NUM_THREADS)-1:0] inc_tid,
    input  logic                           wr_en,
    input  logic [$clog2(NUM_THREADS)-1:0] wr_tid,
    input  logic [ADDRESS_WIDTH-1:0]       wr_pc
);
    import mt_pkg::*;

    localparam int unsigned TW = $clog2(NUM_THREADS);

    logic [ADDRESS_WIDTH-1:0] pc_q [NUM_THREADS];
    logic [ADDRESS_WIDTH-1:0] pc_d [NUM_THREADS];

    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            pc_d[t] = pc_q[t];
            if (inc_en && inc_tid == TW'(t)) begin
                pc_d[t] = pc_q[t] + ADDRESS_WIDTH'(PC_INC);
            end
            if (wr_en && wr_tid == TW'(t)) begin
                pc_d[t] = {wr_pc[ADDRESS_WIDTH-1:2], 2'b00};
            end
        end
    end

    for (genvar g = 0; g < NUM_THREADS; g++) begin : g_pc
        localparam logic [ADDRESS_WIDTH-1:0] RawPc =
            RESET_PC + ADDRESS_WIDTH'(g) * THREAD_PC_STRIDE;

        always_ff @(posedge clk) begin
            if (rst) begin
                pc_q[g] <= {RawPc[ADDRESS_WIDTH-1:2], 2'b00};
            end else begin
                pc_q[g] <= pc_d[g];
            end
        end
    end

    assign rd_pc = pc_q[rd_tid];

endmodule

// File: rtl/barrel_thread_sched.sv
// Barrel-threaded fetch front end: strict round-robin over all hardware threads,
// one registered (tid, pc) slot per cycle; halted threads keep an empty slot.
module barrel_thread_sched #(
    parameter int unsigned                 NUM_THREADS      = mt_pkg::NUM_THREADS,
    parameter int unsigned                 ADDRESS_WIDTH    = mt_pkg::ADDRESS_WIDTH,
    parameter logic [ADDRESS_WIDTH-1:0]    RESET_PC         = mt_pkg::RESET_PC,
    parameter logic [ADDRESS_WIDTH-1:0]    THREAD_PC_STRIDE = mt_pkg::THREAD_PC_STRIDE
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           redirect_valid,
    input  logic [$clog2(NUM_THREADS)-1:0] redirect_tid,
    input  logic [ADDRESS_WIDTH-1:0]       redirect_pc,
    input  logic                           halt_valid,
    input  logic [$clog2(NUM_THREADS)-1:0] halt_tid,
    output logic                           fetch_valid,
    output logic [$clog2(NUM_THREADS)-1:0] fetch_tid,
    output logic [ADDRESS_WIDTH-1:0]       fetch_pc,
    output logic                           all_halted
);
    import mt_pkg::*;

    localparam int unsigned TW = $clog2(NUM_THREADS);

    logic [TW-1:0]            cur_tid_q, cur_tid_d;
    logic [NUM_THREADS-1:0]   active_q, active_d;
    logic [ADDRESS_WIDTH-1:0] cur_pc;
    logic                     inc_en, wr_en;

    always_comb begin
        active_d = active_q;
        if (halt_valid) begin
            active_d[halt_tid] = 1'b0;
        end
        // Halt beats a same-tid redirect; redirects to retired threads are dropped.
        wr_en  = redirect_valid && active_q[redirect_tid] &&
                 !(halt_valid && halt_tid == redirect_tid);
        inc_en = !stall && active_q[cur_tid_q];
        if (stall) begin
            cur_tid_d = cur_tid_q;
        end else if (cur_tid_q == TW'(NUM_THREADS - 1)) begin
            cur_tid_d = '0;
        end else begin
            cur_tid_d = cur_tid_q + 1'b1;
        end
    end

    thread_pc_file #(
        .NUM_THREADS      (NUM_THREADS),
        .ADDRESS_WIDTH    (ADDRESS_WIDTH),
        .RESET_PC         (RESET_PC),
        .THREAD_PC_STRIDE (THREAD_PC_STRIDE)
    ) u_pc_file (
        .clk     (clk),
        .rst     (rst),
        .rd_tid  (cur_tid_q),
        .rd_pc   (cur_pc),
        .inc_en  (inc_en),
        .inc_tid (cur_tid_q),
        .wr_en   (wr_en),
        .wr_tid  (redirect_tid),
        .wr_pc   (redirect_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_tid_q   <= '0;
            active_q    <= '1;
            fetch_valid <= 1'b0;
            fetch_tid   <= '0;
            fetch_pc    <= RESET_PC;
            all_halted  <= 1'b0;
        end else begin
            cur_tid_q  <= cur_tid_d;
            active_q   <= active_d;
            all_halted <= ~|active_q;
            if (!stall) begin
                fetch_valid <= active_q[cur_tid_q];
                fetch_tid   <= cur_tid_q;
                fetch_pc    <= cur_pc;
            end
        end
    end

endmodule

// File: tb/tb_barrel_thread_sched.sv
// Table-driven bench for barrel_thread_sched: each record's expected slot is queued
// as it is driven and compared after the clock edge that produces it.
module tb_barrel_thread_sched;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid, halt_valid;
    logic [1:0]  redirect_tid, halt_tid;
    logic [31:0] redirect_pc;
    logic        fetch_valid, all_halted;
    logic [1:0]  fetch_tid;
    logic [31:0] fetch_pc;

    always #5 clk = ~clk;

    barrel_thread_sched dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_tid   (redirect_tid),
        .redirect_pc    (redirect_pc),
        .halt_valid     (halt_valid),
        .halt_tid       (halt_tid),
        .fetch_valid    (fetch_valid),
        .fetch_tid      (fetch_tid),
        .fetch_pc       (fetch_pc),
        .all_halted     (all_halted)
    );

    typedef struct {
        logic        rst, stall, rv;
        logic [1:0]  rtid;
        logic [31:0] rpc;
        logic        hv;
        logic [1:0]  htid;
        logic        ev;
        logic [1:0]  et;
        logic [31:0] ep;
        logic        eah;
    } vec_t;

    typedef struct packed {
        logic        v;
        logic [1:0]  t;
        logic [31:0] pc;
        logic        ah;
    } slot_t;

    vec_t  vecs[$];
    slot_t sb[$];
    int    checks = 0;
    int    errors = 0;

    function automatic void add(input logic r, input logic s, input logic rv,
                                input logic [1:0] rt, input logic [31:0] rp,
                                input logic hv, input logic [1:0] ht,
                                input logic ev, input logic [1:0] et,
                                input logic [31:0] ep, input logic eah);
        vec_t v;
        v.rst = r;   v.stall = s; v.rv = rv; v.rtid = rt; v.rpc = rp;
        v.hv  = hv;  v.htid = ht; v.ev = ev; v.et = et;   v.ep = ep; v.eah = eah;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v, input string name);
        slot_t got, exp;
        rst            = v.rst;
        stall          = v.stall;
        redirect_valid = v.rv;
        redirect_tid   = v.rtid;
        redirect_pc    = v.rpc;
        halt_valid     = v.hv;
        halt_tid       = v.htid;
        sb.push_back('{v: v.ev, t: v.et, pc: v.ep, ah: v.eah});
        @(posedge clk);
        #1;
        got = '{v: fetch_valid, t: fetch_tid, pc: fetch_pc, ah: all_halted};
        exp = sb.pop_front();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got v=%0b tid=%0d pc=%h halted=%0b, expected v=%0b tid=%0d pc=%h halted=%0b",
                     name, got.v, got.t, got.pc, got.ah, exp.v, exp.t, exp.pc, exp.ah);
        end
    endtask

    initial begin
        vec_t hv;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_tid = '0;
        redirect_pc = '0; halt_valid = 1'b0; halt_tid = '0;

        //   rst st rv rt rpc           hv ht   v  t  pc            ah
        add(1, 0, 0, 0, 32'h0,        0, 0,   0, 0, 32'h0000_0000, 0); // reset
        add(1, 0, 0, 0, 32'h0,        0, 0,   0, 0, 32'h0000_0000, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0000_0000, 0); // free run
        add(0, 0, 0, 0, 32'h0,        0, 0,   1, 1, 32'h0000_0100, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0,   1, 2, 32'h0000_0200, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0,   1, 3, 32'h0000_0300, 0);
        add(0, 0, 1, 2, 32'h1003,     0, 0,   1, 0, 32'h0000_0004, 0); // redirect t2
        add(0, 0, 1, 1, 32'h2000,     0, 0,   1, 1, 32'h0000_0104, 0); // same-slot redirect
        add(0, 0, 0, 0, 32'h0,        0, 0,   1, 2, 32'h0000_1000, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0,   1, 3, 32'h0000_0304, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0000_0008, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0,   1, 1, 32'h0000_2000, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0,   1, 2, 32'h0000_1004, 0);
        add(0, 1, 1, 3, 32'h3000,     0, 0,   1, 2, 32'h0000_1004, 0); // stall x3
        add(0, 1, 0, 0, 32'h0,        0, 0,   1, 2, 32'h0000_1004, 0);
        add(0, 1, 0, 0, 32'h0,        0, 0,   1, 2, 32'h0000_1004, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0,   1, 3, 32'h0000_3000, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0000_000c, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0,   1, 1, 32'h0000_2004, 0);
        add(0, 0, 0, 0, 32'h0,        1, 1,   1, 2, 32'h0000_1008, 0); // halt t1
        add(0, 0, 1, 0, 32'h5000,     1, 0,   1, 3, 32'h0000_3004, 0); // halt+redirect t0
        add(0, 0, 0, 0, 32'h0,        0, 0,   0, 0, 32'h0000_0010, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0,   0, 1, 32'h0000_2008, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0,   1, 2, 32'h0000_100c, 0);
        add(0, 0, 1, 1, 32'h7000,     0, 0,   1, 3, 32'h0000_3008, 0); // redirect halted
        add(0, 0, 0, 0, 32'h0,        0, 0,   0, 0, 32'h0000_0010, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0,   0, 1, 32'h0000_2008, 0);
        add(0, 0, 0, 0, 32'h0,        1, 2,   1, 2, 32'h0000_1010, 0); // halt own slot
        add(0, 0, 0, 0, 32'h0,        1, 3,   1, 3, 32'h0000_300c, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0,   0, 0, 32'h0000_0010, 1); // all halted
        add(0, 0, 0, 0, 32'h0,        0, 0,   0, 1, 32'h0000_2008, 1);
        add(1, 1, 1, 2, 32'h9000,     1, 0,   0, 0, 32'h0000_0000, 0); // mid-run reset
        add(0, 0, 0, 0, 32'h0,        0, 0,   1, 0, 32'h0000_0000, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0,   1, 1, 32'h0000_0100, 0);
        add(0, 0, 0, 0, 32'h0,        0, 0,   1, 2, 32'h0000_0200, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // PC wraps modulo 2^32 after a redirect to the top of the address space.
        hv = '{rst: 0, stall: 0, rv: 1, rtid: 0, rpc: 32'hffff_ffff, hv: 0, htid: 0,
               ev: 1, et: 3, ep: 32'h0000_0300, eah: 0};
        apply(hv, "wrap_redirect");
        hv.rv = 0;
        hv.et = 0; hv.ep = 32'hffff_fffc; apply(hv, "wrap_top");
        hv.et = 1; hv.ep = 32'h0000_0104; apply(hv, "wrap_t1");
        hv.et = 2; hv.ep = 32'h0000_0204; apply(hv, "wrap_t2");
        hv.et = 3; hv.ep = 32'h0000_0304; apply(hv, "wrap_t3");
        hv.et = 0; hv.ep = 32'h0000_0000; apply(hv, "wrap_zero");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
